// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and sizing for the FIFO stream reader.
//   state_t   - reader control states (IDLE, RUN, DRAIN)
//   BUF_DEPTH - number of words the output buffer can hold
//   OCC_W     - width of the buffer occupancy count (0..BUF_DEPTH)
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry strictly ordered word buffer that absorbs the
// one-cycle FIFO read latency in front of the stream output.
// Ports:
//   clk, rst              clock and synchronous active-high reset (flushes)
//   push, push_data       write one word at the tail
//   pop                   remove the head word (caller guarantees occ != 0)
//   occ                   number of buffered words (0..2)
//   head_valid, head_data the word currently presented downstream
// Push and pop may coincide at any occupancy; the caller never pushes into
// a full buffer without popping in the same cycle.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_W-1:0]      occ,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] entry0_r;  // head
  logic [DATA_WIDTH-1:0] entry1_r;  // tail when two words are held
  logic [OCC_W-1:0]      occ_r;

  // Buffer storage and occupancy; entry1 shifts into entry0 on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_r <= {DATA_WIDTH{1'b0}};
      entry1_r <= {DATA_WIDTH{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      case (occ_r)
        OCC_W'(0): begin
          if (push) begin
            entry0_r <= push_data;
            occ_r    <= OCC_W'(1);
          end
        end
        OCC_W'(1): begin
          if (push && pop) begin
            entry0_r <= push_data;
          end else if (push) begin
            entry1_r <= push_data;
            occ_r    <= OCC_W'(2);
          end else if (pop) begin
            occ_r    <= OCC_W'(0);
          end
        end
        OCC_W'(2): begin
          if (pop) begin
            entry0_r <= entry1_r;
            if (push) begin
              entry1_r <= push_data;
            end else begin
              occ_r    <= OCC_W'(1);
            end
          end
        end
        default: occ_r <= {OCC_W{1'b0}};
      endcase
    end
  end

  assign occ        = occ_r;
  assign head_valid = (occ_r != {OCC_W{1'b0}});
  assign head_data  = entry0_r;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO read port (data valid one
// cycle after rd_en) and re-presents the words as a valid/ready stream with
// frame delimiting on m_last.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable                   permits new FIFO reads
//   fifo_empty, fifo_data_out, fifo_rd_en   FIFO read interface
//   frame_len                beats per frame (0 treated as 1), sampled at
//                            the first beat of each frame
//   m_data, m_valid, m_ready, m_last        output stream
//   busy                     controller not IDLE
// Optional build macro FIFO_READER_STATS_EN adds saturating counters:
//   stat_words (pops) and stat_stall (cycles with m_valid & !m_ready).
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  input  logic [LEN_W-1:0]      frame_len,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_stall
`endif
);

  localparam int                SUM_W     = OCC_W + 1;
  localparam logic [SUM_W-1:0]  BUF_LIMIT = SUM_W'(BUF_DEPTH);
  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t                state_r, state_next_s;
  logic                  inflight_r;
  logic [LEN_W-1:0]      beat_cnt_r;
  logic [LEN_W-1:0]      len_r;
  logic                  len_held_r;
  logic [OCC_W-1:0]      occ_s;
  logic                  head_valid_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic                  pop_s;
  logic                  rd_en_s;
  logic [SUM_W-1:0]      in_dut_s;
  logic [LEN_W-1:0]      len_live_s;
  logic [LEN_W-1:0]      len_cur_s;
  logic                  last_s;

  assign pop_s = head_valid_s & m_ready;

  // Words already committed to the buffer: stored plus the one still in the
  // FIFO's output register. A pop this cycle frees a slot for a new read.
  assign in_dut_s = {1'b0, occ_s} + {{OCC_W{1'b0}}, inflight_r};
  assign rd_en_s  = (state_r == RUN) & enable & ~fifo_empty &
                    (in_dut_s < (BUF_LIMIT + {{OCC_W{1'b0}}, pop_s}));

  fifo_reader_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_r),
    .push_data  (fifo_data_out),
    .pop        (pop_s),
    .occ        (occ_s),
    .head_valid (head_valid_s),
    .head_data  (head_data_s)
  );

  // Until the first beat of a frame has been latched, the live frame_len is
  // used so m_last is correct in the very first presentation cycle.
  assign len_live_s = (frame_len == LEN_ZERO) ? LEN_ONE : frame_len;
  assign len_cur_s  = len_held_r ? len_r : len_live_s;
  assign last_s     = (beat_cnt_r == (len_cur_s - LEN_ONE));

  // State register and read-in-flight marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      inflight_r <= rd_en_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_next_s = RUN;
        else        state_next_s = IDLE;
      end
      RUN: begin
        if (!enable) state_next_s = DRAIN;
        else         state_next_s = RUN;
      end
      DRAIN: begin
        if (enable)                                               state_next_s = RUN;
        else if ((occ_s == {OCC_W{1'b0}}) && !inflight_r)         state_next_s = IDLE;
        else                                                      state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Beat counter and per-frame length latch; both survive enable toggling.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r <= LEN_ZERO;
      len_r      <= LEN_ZERO;
      len_held_r <= 1'b0;
    end else begin
      if (pop_s) begin
        beat_cnt_r <= last_s ? LEN_ZERO : (beat_cnt_r + LEN_ONE);
      end
      if (pop_s && last_s) begin
        len_held_r <= 1'b0;
      end else if (head_valid_s && !len_held_r) begin
        len_r      <= len_live_s;
        len_held_r <= 1'b1;
      end
    end
  end

`ifdef FIFO_READER_STATS_EN
  logic [31:0] stat_words_r;
  logic [31:0] stat_stall_r;

  // Saturating pop and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words_r <= 32'd0;
      stat_stall_r <= 32'd0;
    end else begin
      if (pop_s && (stat_words_r != 32'hFFFF_FFFF)) begin
        stat_words_r <= stat_words_r + 32'd1;
      end
      if (head_valid_s && !m_ready && (stat_stall_r != 32'hFFFF_FFFF)) begin
        stat_stall_r <= stat_stall_r + 32'd1;
      end
    end
  end

  assign stat_words = stat_words_r;
  assign stat_stall = stat_stall_r;
`endif

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = head_valid_s;
  assign m_data     = head_data_s;
  assign m_last     = head_valid_s & last_s;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed scoreboard bench for fifo_stream_reader.
// A behavioural synchronous FIFO feeds the DUT; every word written is also
// queued with its hand-computed m_last; a monitor compares each pop.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_rd_en;
  logic [LW-1:0] frame_len;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
`ifdef FIFO_READER_STATS_EN
  logic [31:0]   stat_words;
  logic [31:0]   stat_stall;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .frame_len     (frame_len),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .busy          (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .stat_words    (stat_words),
    .stat_stall    (stat_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural FIFO (registered read data) --------------
  logic [DW-1:0] fmem [0:63];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (rst) begin
      rd_cnt        <= wr_cnt;
      fifo_data_out <= '0;
    end else if (fifo_rd_en) begin
      fifo_data_out <= fmem[rd_cnt % 64];
      rd_cnt        <= rd_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  task automatic write_word(input logic [DW-1:0] d, input logic l);
    exp_t e;
    fmem[wr_cnt % 64] = d;
    wr_cnt++;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  int   pops = 0;
  int   mon_words = 0;
  int   mon_stall = 0;
  int   in_dut = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;
  exp_t mon_e;

  // Monitor: compares pops against the queue, checks hold-during-stall and
  // the read-issue bound on every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_dut     = 0;
        prev_stall = 1'b0;
        mon_words  = 0;
        mon_stall  = 0;
      end else begin
        if (fifo_rd_en) begin
          check("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
          check("rd_en_bound", {31'd0, ((in_dut - int'(m_valid & m_ready)) < 2)}, 32'd1);
        end
        if (prev_stall) begin
          check("hold_valid", {31'd0, m_valid}, 32'd1);
          check("hold_data", {24'd0, m_data}, {24'd0, prev_data});
          check("hold_last", {31'd0, m_last}, {31'd0, prev_last});
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got 0x%0h, expected no word", m_data);
          end else begin
            mon_e = exp_q.pop_front();
            check("data", {24'd0, m_data}, {24'd0, mon_e.data});
            check("last", {31'd0, m_last}, {31'd0, mon_e.last});
          end
          pops++;
          mon_words++;
        end
        if (m_valid && !m_ready) mon_stall++;
        in_dut     = in_dut + int'(fifo_rd_en) - int'(m_valid & m_ready);
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
    repeat (3) tick();
  endtask

  task automatic wait_pops(input string name, input int target, input int bound);
    int n = 0;
    while (pops < target && n < bound) begin
      tick();
      n++;
    end
    check(name, {31'd0, (pops >= target)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int base;
    int bad;
    rst       = 1'b1;
    enable    = 1'b0;
    m_ready   = 1'b0;
    frame_len = 16'd4;
    tick();
    tick();
    @(negedge clk);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_data", {24'd0, m_data}, 32'd0);
    check("rst_last", {31'd0, m_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;

    // T1: 0x01..0x08, frame_len 4, full throughput
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) write_word(8'(i), (i % 4) == 0);
    enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!fifo_rd_en && n < 20);
    check("first_rd_en_seen", {31'd0, fifo_rd_en}, 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 10);
    check("first_beat_latency", n, 32'd2);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!m_valid) break;
      n++;
    end
    check("back_to_back_beats", n, 32'd8);
    wait_empty("t1_drain", 40);
    @(negedge clk);
    check("t1_busy", {31'd0, busy}, 32'd1);

    // T2: same load with m_ready toggling
    tick();
    for (int i = 1; i <= 8; i++) write_word(8'(i), (i % 4) == 0);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      m_ready = ~m_ready;
      n++;
    end
    check("t2_drain", exp_q.size(), 32'd0);
    m_ready = 1'b1;
    repeat (3) tick();

    // T3: empty FIFO, enabled for 20 cycles, then a single 0xA5
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fifo_rd_en || m_valid) bad++;
    end
    check("t3_quiet", bad, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd1);
    tick();
    frame_len = 16'd0;   // treated as 1: every beat is last
    write_word(8'hA5, 1'b1);
    wait_empty("t3_single", 20);
    repeat (5) tick();

    // T4: frame of 6, enable dropped after 3 beats, then resumed
    frame_len = 16'd6;
    base = pops;
    for (int i = 1; i <= 6; i++) write_word(8'h10 + 8'(i), i == 6);
    wait_pops("t4_three_pops", base + 3, 30);
    enable = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 20);
    check("t4_idle", {31'd0, busy}, 32'd0);
    check("t4_delivered", pops - base, 32'd5);
    check("t4_word_left", {31'd0, (wr_cnt != rd_cnt)}, 32'd1);
    tick();
    enable = 1'b1;
    wait_empty("t4_resume", 30);

    // T5: reset with a full buffer in the middle of a frame
    frame_len = 16'd4;
    base = pops;
    for (int i = 1; i <= 4; i++) write_word(8'h30 + 8'(i), i == 4);
    wait_pops("t5_first_pop", base + 1, 30);
    m_ready = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("t5_pre_valid", {31'd0, m_valid}, 32'd1);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid_cleared", {31'd0, m_valid}, 32'd0);
    check("t5_rd_en_cleared", {31'd0, fifo_rd_en}, 32'd0);
    check("t5_busy_cleared", {31'd0, busy}, 32'd0);
    tick();
    frame_len = 16'd2;
    m_ready   = 1'b1;
    write_word(8'h41, 1'b0);
    write_word(8'h42, 1'b1);
    wait_empty("t5_new_frame", 30);

`ifdef FIFO_READER_STATS_EN
    // T6: 8 pops and exactly 5 stall cycles after a reset
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    m_ready   = 1'b0;
    frame_len = 16'd4;
    for (int i = 1; i <= 8; i++) write_word(8'h50 + 8'(i), (i % 4) == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 20);
    repeat (5) @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_empty("t6_drain", 40);
    check("stat_words", stat_words, 32'd8);
    check("stat_stall", stat_stall, 32'd5);
    check("stat_words_model", stat_words, mon_words);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
